// File: rtl/ppa_slice_arbiter_if.sv
// Requester, response and shared-adder-slice signals of ppa_slice_arbiter.
// master = requesters plus external adder slice; slave = the arbiter.
interface ppa_slice_arbiter_if #(
  parameter int SLICE_W = 8,
  parameter int NSLICE  = 4
);
  localparam int W = SLICE_W * NSLICE;

  logic               req0_valid, req1_valid;
  logic               req0_ready, req1_ready;
  logic [W-1:0]       req0_a, req0_b, req1_a, req1_b;
  logic               req0_cin, req1_cin;
  logic               rsp0_valid, rsp1_valid;
  logic               rsp0_ready, rsp1_ready;
  logic [W-1:0]       rsp0_sum, rsp1_sum;
  logic               rsp0_cout, rsp1_cout;
  logic [SLICE_W-1:0] add_a, add_b, add_sum;
  logic               add_cin, add_cout;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cin, req1_cin,
    output rsp0_ready, rsp1_ready, add_sum, add_cout,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_sum, rsp1_sum,
    input  rsp0_cout, rsp1_cout, add_a, add_b, add_cin
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_cin, req1_cin,
    input  rsp0_ready, rsp1_ready, add_sum, add_cout,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_sum, rsp1_sum,
    output rsp0_cout, rsp1_cout, add_a, add_b, add_cin
  );
endinterface

// File: rtl/ppa_slice_arbiter.sv
// Round-robin arbiter time-sharing one SLICE_W adder slice for two W-bit add requesters.
// Result appears NSLICE cycles after acceptance and is held until the owner's rsp_ready.
module ppa_slice_arbiter #(
  parameter int SLICE_W = 8,
  parameter int NSLICE  = 4
) (
  input  logic               clk,
  input  logic               rst,
  ppa_slice_arbiter_if.slave bus,
  output logic               busy
);
  localparam int W  = SLICE_W * NSLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic          cin_q, cin_d, carry_q, carry_d;
  logic          owner_q, owner_d, last_grant_q, last_grant_d;
  logic          grant0, grant1, owner_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      cin_q        <= 1'b0;
      carry_q      <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      cin_q        <= cin_d;
      carry_q      <= carry_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // On a tie the requester not granted last wins; ready is held low during reset.
  assign grant0 = !rst && bus.req0_valid && (!bus.req1_valid || last_grant_q);
  assign grant1 = !rst && bus.req1_valid && (!bus.req0_valid || !last_grant_q);
  assign owner_rsp_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    a_d            = a_q;
    b_d            = b_q;
    result_d       = result_q;
    cin_d          = cin_q;
    carry_d        = carry_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.add_a      = '0;
    bus.add_b      = '0;
    bus.add_cin    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        if (grant0 || grant1) begin
          owner_d      = grant1;
          last_grant_d = grant1;
          a_d          = grant1 ? bus.req1_a : bus.req0_a;
          b_d          = grant1 ? bus.req1_b : bus.req0_b;
          cin_d        = grant1 ? bus.req1_cin : bus.req0_cin;
          k_d          = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        bus.add_a   = a_q[k_q*SLICE_W +: SLICE_W];
        bus.add_b   = b_q[k_q*SLICE_W +: SLICE_W];
        bus.add_cin = (k_q == '0) ? cin_q : carry_q;
        result_d[k_q*SLICE_W +: SLICE_W] = bus.add_sum;
        carry_d = bus.add_cout;
        if (k_q == KW'(NSLICE - 1)) begin
          k_d     = '0;
          state_d = RESP;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      RESP: begin
        if (owner_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The carry register holds the top slice's carry-out once the operation completes.
  assign bus.rsp0_valid = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid = (state_q == RESP) && owner_q;
  assign bus.rsp0_sum   = result_q;
  assign bus.rsp1_sum   = result_q;
  assign bus.rsp0_cout  = carry_q;
  assign bus.rsp1_cout  = carry_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_ppa_slice_arbiter.sv
// Self-checking bench for ppa_slice_arbiter: directed scenarios plus randomized traffic
// against an arithmetic reference with a round-robin grant model.
module tb_ppa_slice_arbiter;
  localparam int SLICE_W = 8;
  localparam int NSLICE  = 4;
  localparam int W       = SLICE_W * NSLICE;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   compared   = 0;
  int   mismatched = 0;

  ppa_slice_arbiter_if #(.SLICE_W(SLICE_W), .NSLICE(NSLICE)) bus ();

  ppa_slice_arbiter #(.SLICE_W(SLICE_W), .NSLICE(NSLICE)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // External shared adder slice, purely combinational.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b}
                                       + {{SLICE_W{1'b0}}, bus.add_cin};

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic req_rdy(input int p);
    return (p != 0) ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rsp_vld(input int p);
    return (p != 0) ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  function automatic logic [W:0] rsp_res(input int p);
    return (p != 0) ? {bus.rsp1_cout, bus.rsp1_sum} : {bus.rsp0_cout, bus.rsp0_sum};
  endfunction

  function automatic logic [87:0] outs_vec();
    return {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_cout,
            bus.rsp1_cout, bus.add_cin, busy, bus.add_a, bus.add_b, bus.rsp0_sum, bus.rsp1_sum};
  endfunction

  task automatic set_req(input int p, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
    if (p != 0) begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = c;
    end else begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = c;
    end
  endtask

  task automatic set_rsp_rdy(input int p, input logic r);
    if (p != 0) bus.rsp1_ready = r;
    else        bus.rsp0_ready = r;
  endtask

  // Drives one operation on port p and reports what was observed.
  task automatic run_op(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input int stall, output logic ok, output int lat,
                        output logic [W:0] res, output logic [NSLICE-1:0] cins,
                        output logic other_vld, output logic stable, output logic idle_after);
    int t;
    ok = 1'b0; lat = 0; res = '0; cins = '0; other_vld = 1'b0; stable = 1'b1;
    idle_after = 1'b0;
    @(negedge clk);
    set_req(p, 1'b1, a, b, c);
    #1;
    t = 0;
    while (!req_rdy(p) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    if (!req_rdy(p)) begin
      set_req(p, 1'b0, '0, '0, 1'b0);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    set_req(p, 1'b0, $urandom(), $urandom(), 1'($urandom_range(0, 1)));
    #1;
    while (!rsp_vld(p) && lat < 20) begin
      if (lat < NSLICE) cins[lat] = bus.add_cin;
      if (rsp_vld(1 - p)) other_vld = 1'b1;
      @(negedge clk); #1; lat++;
    end
    if (!rsp_vld(p)) return;
    ok = 1'b1;
    res = rsp_res(p);
    if (rsp_vld(1 - p)) other_vld = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk); #1;
      if (!rsp_vld(p) || rsp_res(p) !== res) stable = 1'b0;
    end
    set_rsp_rdy(p, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_rsp_rdy(p, 1'b0);
    #1;
    idle_after = !busy && !rsp_vld(p);
  endtask

  task automatic test_reset();
    logic [87:0] o;
    rst = 1'b1;
    set_req(0, 1'b1, $urandom(), $urandom(), 1'b1);
    set_req(1, 1'b1, $urandom(), $urandom(), 1'b1);
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    @(negedge clk); #1;
    o = outs_vec();
    compared++;
    if (o !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got %h, required 0", o);
    end
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    rst = 1'b0;
    #1;
    o = outs_vec();
    compared++;
    if (o !== '0) begin
      mismatched++;
      $display("FAIL idle_after_reset: got %h, required 0", o);
    end
  endtask

  task automatic test_carry_chain();
    logic ok, ov, st, ia; int lat; logic [W:0] res, exp; logic [NSLICE-1:0] cins;
    logic [W-1:0] a, b;
    a = 32'hFFFF_FFFF; b = 32'h0000_0000;
    exp = ref_add(a, b, 1'b1);
    run_op(0, a, b, 1'b1, 0, ok, lat, res, cins, ov, st, ia);
    compared++;
    if (ok !== 1'b1) begin mismatched++; $display("FAIL cc_handshake: ok=%0b, required 1", ok); end
    compared++;
    if (lat !== NSLICE) begin mismatched++; $display("FAIL cc_latency: got %0d, required %0d", lat, NSLICE); end
    compared++;
    if (res !== exp) begin mismatched++; $display("FAIL cc_result: got %h, required %h", res, exp); end
    compared++;
    if (ov !== 1'b0) begin mismatched++; $display("FAIL cc_rsp1_quiet: rsp1_valid seen=%0b, required 0", ov); end
  endtask

  task automatic test_slice_carry();
    logic ok, ov, st, ia; int lat; logic [W:0] res, exp, lo; logic [NSLICE-1:0] cins, exp_c;
    logic [W-1:0] a, b, m;
    a = 32'h0000_00FF; b = 32'h0000_0001;
    exp = ref_add(a, b, 1'b0);
    for (int k = 0; k < NSLICE; k++) begin
      m = (k == 0) ? '0 : ({W{1'b1}} >> (W - k * SLICE_W));
      lo = ref_add(a & m, b & m, 1'b0);
      exp_c[k] = lo[k * SLICE_W];
    end
    run_op(1, a, b, 1'b0, 0, ok, lat, res, cins, ov, st, ia);
    compared++;
    if (res !== exp) begin mismatched++; $display("FAIL sc_result: got %h, required %h", res, exp); end
    compared++;
    if (cins !== exp_c) begin mismatched++; $display("FAIL sc_add_cin: got %b, required %b", cins, exp_c); end
    compared++;
    if (lat !== NSLICE) begin mismatched++; $display("FAIL sc_latency: got %0d, required %0d", lat, NSLICE); end
  endtask

  task automatic test_stall();
    logic ok, ov, st, ia, c; int lat; logic [W:0] res, exp; logic [NSLICE-1:0] cins;
    logic [W-1:0] a, b;
    a = $urandom(); b = $urandom(); c = 1'($urandom_range(0, 1));
    exp = ref_add(a, b, c);
    run_op(0, a, b, c, 5, ok, lat, res, cins, ov, st, ia);
    compared++;
    if (res !== exp) begin mismatched++; $display("FAIL st_result: got %h, required %h", res, exp); end
    compared++;
    if (st !== 1'b1) begin mismatched++; $display("FAIL st_stable: got %0b, required 1", st); end
    compared++;
    if (ia !== 1'b1) begin mismatched++; $display("FAIL st_idle_after: got %0b, required 1", ia); end
  endtask

  task automatic test_reset_mid_run();
    logic ok, ov, st, ia, c, seen; int lat; logic [W:0] res, exp; logic [NSLICE-1:0] cins;
    logic [W-1:0] a, b; logic [87:0] o; logic [SLICE_W-1:0] exp_s;
    a = $urandom(); b = $urandom(); c = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, a, b, c);
    #1;
    compared++;
    if (bus.req0_ready !== 1'b1) begin mismatched++; $display("FAIL rr_accept: ready=%0b, required 1", bus.req0_ready); end
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    exp_s = a[2 * SLICE_W +: SLICE_W];
    compared++;
    if (bus.add_a !== exp_s) begin mismatched++; $display("FAIL rr_slice2: add_a=%h, required %h", bus.add_a, exp_s); end
    #1 rst = 1'b1;
    #1;
    o = outs_vec();
    compared++;
    if (o !== '0) begin mismatched++; $display("FAIL rr_async_outputs: got %h, required 0", o); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (bus.rsp0_valid || bus.rsp1_valid || busy) seen = 1'b1;
    end
    compared++;
    if (seen !== 1'b0) begin mismatched++; $display("FAIL rr_no_replay: activity=%0b, required 0", seen); end
    a = $urandom(); b = $urandom();
    exp = ref_add(a, b, 1'b0);
    run_op(0, a, b, 1'b0, 0, ok, lat, res, cins, ov, st, ia);
    compared++;
    if (res !== exp) begin mismatched++; $display("FAIL rr_next_op: got %h, required %h", res, exp); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] a0, b0, a1, b1; logic c0, c1; logic [W:0] e0, e1;
    int grants[$]; int times[$]; int prev, cyc;
    a0 = $urandom(); b0 = $urandom(); c0 = 1'b0;
    a1 = $urandom(); b1 = $urandom(); c1 = 1'b1;
    e0 = ref_add(a0, b0, c0); e1 = ref_add(a1, b1, c1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 1'b1, a0, b0, c0);
    set_req(1, 1'b1, a1, b1, c1);
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    #1;
    cyc = 0;
    while (grants.size() < 4 && cyc < 100) begin
      if (bus.req0_ready && bus.req1_ready) begin
        compared++; mismatched++;
        $display("FAIL rb_double_ready: both ready at cycle %0d, required at most one", cyc);
      end
      if (bus.req0_ready) begin grants.push_back(0); times.push_back(cyc); end
      else if (bus.req1_ready) begin grants.push_back(1); times.push_back(cyc); end
      if (bus.rsp0_valid) begin
        compared++;
        if ({bus.rsp0_cout, bus.rsp0_sum} !== e0) begin
          mismatched++; $display("FAIL rb_rsp0: got %h, required %h", {bus.rsp0_cout, bus.rsp0_sum}, e0);
        end
      end
      if (bus.rsp1_valid) begin
        compared++;
        if ({bus.rsp1_cout, bus.rsp1_sum} !== e1) begin
          mismatched++; $display("FAIL rb_rsp1: got %h, required %h", {bus.rsp1_cout, bus.rsp1_sum}, e1);
        end
      end
      @(negedge clk); #1; cyc++;
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    compared++;
    if (grants.size() !== 4) begin
      mismatched++; $display("FAIL rb_grant_count: got %0d, required 4", grants.size());
    end
    prev = 1;
    foreach (grants[i]) begin
      compared++;
      if (grants[i] !== 1 - prev) begin
        mismatched++; $display("FAIL rb_order[%0d]: got %0d, required %0d", i, grants[i], 1 - prev);
      end
      prev = 1 - prev;
      if (i > 0) begin
        compared++;
        if (times[i] - times[i-1] !== NSLICE + 2) begin
          mismatched++;
          $display("FAIL rb_interval[%0d]: got %0d, required %0d", i, times[i] - times[i-1], NSLICE + 2);
        end
      end
    end
    repeat (12) @(negedge clk);
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [W:0] q0[$], q1[$];
    logic [W:0] e, got;
    logic [W-1:0] a[2], b[2];
    logic c[2];
    bit vld[2], acc[2];
    int waits[2];
    int done, cyc, last, g, o;
    logic r;
    done = 0; cyc = 0; last = 1;
    for (int p = 0; p < 2; p++) begin vld[p] = 0; acc[p] = 0; waits[p] = 0; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    while (done < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin vld[p] = 0; acc[p] = 0; end
        if (!vld[p] && $urandom_range(0, 3) != 0) begin
          vld[p] = 1; a[p] = $urandom(); b[p] = $urandom(); c[p] = 1'($urandom_range(0, 1));
        end
        if (vld[p]) set_req(p, 1'b1, a[p], b[p], c[p]);
        else        set_req(p, 1'b0, $urandom(), $urandom(), 1'b0);
      end
      #1;
      for (int p = 0; p < 2; p++) begin
        r = ($urandom_range(0, 2) != 0);
        set_rsp_rdy(p, r);
        if (rsp_vld(p) && r) begin
          got = rsp_res(p);
          compared++;
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            mismatched++; $display("FAIL rnd_unexpected_rsp%0d: got %h, required none", p, got);
          end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            if (got !== e) begin
              mismatched++; $display("FAIL rnd_result%0d: got %h, required %h", p, got, e);
            end
          end
          done++;
        end
      end
      #1;
      if (bus.req0_ready || bus.req1_ready) begin
        g = (vld[0] && vld[1]) ? 1 - last : (vld[1] ? 1 : 0);
        o = bus.req1_ready ? 1 : 0;
        compared++;
        if ((bus.req0_ready && bus.req1_ready) || o !== g) begin
          mismatched++;
          $display("FAIL rnd_grant: ready0=%0b ready1=%0b, required port %0d", bus.req0_ready, bus.req1_ready, g);
        end
        if (o == 0) q0.push_back(ref_add(a[0], b[0], c[0]));
        else        q1.push_back(ref_add(a[1], b[1], c[1]));
        acc[o] = 1; last = o; waits[o] = 0;
        if (vld[1 - o]) waits[1 - o]++;
        compared++;
        if (waits[1 - o] > 1) begin
          mismatched++; $display("FAIL rnd_starve%0d: waited %0d grants, required <= 1", 1 - o, waits[1 - o]);
        end
      end
    end
    compared++;
    if (done < 1000) begin
      mismatched++; $display("FAIL rnd_progress: completed %0d ops, required 1000", done);
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    repeat (12) @(negedge clk);
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    test_reset();
    test_carry_chain();
    test_slice_carry();
    test_stall();
    test_reset_mid_run();
    test_round_robin();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
